// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges IF/ID/EX stall requests, sequences
// multi-cycle EX operations and counts cycles in which the PC was held.
module pipe_stall_ctrl #(
  parameter int MC_CNT_W = 6,
  parameter int PERF_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_if,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                mc_start,
  input  logic [MC_CNT_W-1:0] mc_cycles,
  input  logic                mc_cancel,
  output logic [5:0]          stall,
  output logic                mc_busy,
  output logic                mc_done,
  output logic [PERF_W-1:0]   stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mc_state_e;

  mc_state_e           state_q;
  logic [MC_CNT_W-1:0] cnt_q;
  logic                busy_q;
  logic [PERF_W-1:0]   stall_cnt_q;
  logic                mc_stall;
  logic                start_ok;

  // A start colliding with a flush is rejected, so it never holds the pipe.
  assign start_ok = (state_q == IDLE) && mc_start && !mc_cancel;
  assign mc_stall = (state_q == RUN) || start_ok;

  always_comb begin
    stall = 6'b000000;
    if (stallreq_ex || mc_stall) begin
      stall = 6'b001111;
    end else if (stallreq_id) begin
      stall = 6'b000111;
    end else if (stallreq_if) begin
      stall = 6'b000011;
    end
  end

  // The done pulse is suppressed on a cycle that aborts the op.
  assign mc_done   = (state_q == DONE) && !mc_cancel && !rst;
  assign mc_busy   = busy_q;
  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (stall[0]) begin
        stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      end

      if (mc_cancel) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (mc_start) begin
              // A length of zero runs exactly like a length of one.
              cnt_q <= (mc_cycles == '0) ? '0 : mc_cycles - MC_CNT_W'(1);
              busy_q <= 1'b1;
              if (mc_cycles > MC_CNT_W'(1)) begin
                state_q <= RUN;
              end else begin
                state_q <= DONE;
              end
            end
          end
          RUN: begin
            cnt_q  <= cnt_q - MC_CNT_W'(1);
            busy_q <= 1'b1;
            if (cnt_q == MC_CNT_W'(1)) begin
              state_q <= DONE;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline stall controller for the 5-stage core. It merges stall requests from IF, ID and EX into the 6-bit `stall` vector consumed by every pipeline register, including the ID/EX register. It also sequences multi-cycle EX operations (divide, multiply-accumulate) by holding the pipeline for a programmed number of cycles. It keeps a free-running stall-cycle performance counter.

## Interface
Parameters:
- `MC_CNT_W`, 6: width of the multi-cycle length field (max 63 cycles).
- `PERF_W`, 32: width of the stall-cycle counter.

Ports:
- `clk` in 1: single clock, all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `stallreq_if` in 1: IF needs to wait (instruction memory not ready).
- `stallreq_id` in 1: ID hazard (load-use).
- `stallreq_ex` in 1: EX external stall request.
- `mc_start` in 1: EX begins a multi-cycle op this cycle.
- `mc_cycles` in MC_CNT_W: op length N; 0 is treated as 1.
- `mc_cancel` in 1: flush; aborts any multi-cycle op.
- `stall` out 6: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
- `mc_busy` out 1: FSM not in IDLE.
- `mc_done` out 1: one-cycle pulse, result valid in EX this cycle.
- `stall_cnt` out PERF_W: count of cycles with stall[0]=1.

## Operation
- FSM states are IDLE, RUN and DONE. `cnt` is a MC_CNT_W down-counter.
- IDLE with `mc_start`=1: an internal multi-cycle stall (`mc_stall`) is asserted this cycle. Load `cnt` <= N-1.
  - N>1: next state RUN.
  - N==1: next state DONE.
- RUN: `mc_stall`=1 and `cnt` decrements. When `cnt`==1, next state is DONE. Total `mc_stall` cycles equal N, including the start cycle.
- DONE: `mc_stall`=0, `mc_done`=1, next state IDLE.
- `mc_start` is ignored in RUN and DONE. A start in IDLE on the cycle right after DONE is accepted.
- `mc_cancel`=1 in any state: next state IDLE and `cnt` <= 0. `mc_done` is not asserted on the cancel cycle. Cancel wins over a simultaneous `mc_start`. The `stall` output on the cancel cycle is still computed from the current state.
- `stall` is combinational from the inputs and current state. Priority, highest first:
  - `stallreq_ex` | `mc_stall` gives 6'b001111.
  - `stallreq_id` gives 6'b000111.
  - `stallreq_if` gives 6'b000011.
  - Otherwise 6'b000000.
- ID/EX inserts a bubble when stall[2]=1 and stall[3]=0. It therefore sees a bubble only for ID stalls, never for EX or multi-cycle stalls.
- `mc_busy` = (state != IDLE), registered from state.
- `stall_cnt` increments by 1 on each posedge where stall[0]=1 and `rst`=0. It wraps from all-ones to 0.

## Timing
- Reset: state IDLE, `cnt`=0, `stall_cnt`=0.
  - Outputs during reset follow the same combinational rules. With all inputs low they are `stall`=0, `mc_busy`=0, `mc_done`=0.
  - `rst` mid-operation aborts the op identically to `mc_cancel` and also clears `stall_cnt`.
- `stall` has 0-cycle latency from the request inputs.
- `mc_start` at cycle T with N:
  - stall[3]=1 for cycles T..T+N-1.
  - `mc_done`=1 at T+N.
  - `mc_busy`=1 for T+1..T+N.
- N=0 behaves exactly as N=1.
- `stallreq_id` concurrent with a multi-cycle op: the output is 6'b001111; ID is held, not bubbled.

## Test plan
- Reset, then `stallreq_if`=1 for 1 cycle -> `stall`=6'b000011 that cycle, `stall_cnt`=1 afterwards.
- `stallreq_id` and `stallreq_if` together -> `stall`=6'b000111; add `stallreq_ex` -> 6'b001111.
- `mc_start` with N=5 at T -> `stall`=6'b001111 for T..T+4, `mc_done` only at T+5, `mc_busy` T+1..T+5, `stall_cnt` +5. Repeat with N=1 and N=0 -> 1 stall cycle, `mc_done` at T+1.
- `mc_start` N=8, then `mc_cancel` at T+3 -> state IDLE at T+4, `stall`=0 at T+4, `mc_done` never pulses. A second `mc_start` at T+4 with N=2 is accepted.
- `mc_start` re-asserted during RUN and DONE -> ignored. A back-to-back start at T+N+1 -> new op, stall again from T+N+1.
- Preload `stall_cnt` near wrap by holding `stallreq_if` for 2^PERF_W cycles (PERF_W=8 variant) -> wraps to 0. Assert `rst` mid-op -> all state cleared next cycle.
